param_nibble_serializer: RTL
============================

PARAM_NIBBLE_SERIALIZER -- requirements
Module: param_NibbleSerializer

Interface
REQ-001 Parameter: NUM_SUBWORDS, default 8, number of subwords per word (power of two, >= 2).
REQ-002 Parameter: SUBWORD_W, default 4, width in bits of one subword.
REQ-003 Derived widths: WORD_W = NUM_SUBWORDS*SUBWORD_W (32 by default); IDX_W = clog2(NUM_SUBWORDS) (3 by default).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_val  input  1  parallel word valid.
REQ-007 in_rdy  output  1  serializer can accept a parallel word.
REQ-008 in_data  input  WORD_W  parallel word to serialize.
REQ-009 out_val  output  1  serial subword valid.
REQ-010 out_rdy  input  1  downstream accepts the subword (deserialized register write enable side).
REQ-011 out_data  output  SUBWORD_W  current subword, LSB-first order.
REQ-012 out_idx  output  IDX_W  subword index of out_data (0 = bits [SUBWORD_W-1:0]).
REQ-013 out_last  output  1  current subword is index NUM_SUBWORDS-1.
REQ-014 busy  output  1  a word is held and not yet fully transferred.

Function
REQ-015 The block SHALL implement two states: IDLE and SEND.
REQ-016 A word SHALL be accepted when in_val && in_rdy on a rising edge; an output beat SHALL fire when out_val && out_rdy.
REQ-017 In IDLE: in_rdy=1, out_val=0, busy=0; on word accept, load shift register with in_data, set index 0, go to SEND.
REQ-018 In SEND: out_val=1, busy=1, out_data = shift register [SUBWORD_W-1:0], out_idx = index, out_last = (index == NUM_SUBWORDS-1).
REQ-019 On a non-last beat fire: shift register shifts right by SUBWORD_W with zero fill; index increments by 1; state stays SEND.
REQ-020 While out_val=1 and out_rdy=0, out_data, out_idx, out_last SHALL hold stable; no state changes.
REQ-021 in_rdy SHALL equal (state==IDLE) || (state==SEND && out_last && out_rdy); this out_rdy-to-in_rdy combinational path is required.
REQ-022 On last beat fire with in_val=1: load new word, index 0, stay SEND (no bubble between words).
REQ-023 On last beat fire with in_val=0: go to IDLE; index 0.
REQ-024 in_data SHALL be ignored on every cycle without a word accept.
REQ-025 Latency: word accepted at edge N -> subword 0 presented (out_val=1) in cycle after edge N; with out_rdy held 1, a word completes in exactly NUM_SUBWORDS cycles; sustained throughput one word per NUM_SUBWORDS cycles.
REQ-026 Index SHALL never exceed NUM_SUBWORDS-1; no wrap through the counter occurs except via reload at 0.
REQ-027 In IDLE, out_data SHALL be the shift register low subword (zero after reset or after full drain) and out_idx = 0.

Reset
REQ-028 Asserting reset at any time, including mid-word, SHALL immediately abort the transfer: state IDLE, index 0, shift register 0.
REQ-029 During reset: in_rdy=1, out_val=0, out_last=0, busy=0, out_data=0, out_idx=0; no beat fires.
REQ-030 After reset deassertion, the first word accept SHALL behave as from IDLE; no partial word is replayed.

Verification
REQ-031 Single word: in_data=32'h8765_4321, out_rdy=1 -> out_data 1,2,3,4,5,6,7,8 on consecutive cycles, out_idx 0..7, out_last only on idx 7, then IDLE.
REQ-032 Back-to-back: 32'hAAAA_AAAA then 32'h0000_000F offered continuously -> 16 consecutive valid beats, in_rdy=1 only on idx 7 beat, idx returns to 0 with data F.
REQ-033 Backpressure: out_rdy=0 for 3 cycles at idx 4 of 32'h8765_4321 -> out_data=5, out_idx=4 held 3 cycles, sequence resumes unchanged.
REQ-034 Last-beat stall: out_rdy=0 at idx 7 with in_val=1 -> in_rdy=0, no new word taken until out_rdy=1.
REQ-035 Reset mid-op: reset asserted at idx 3 -> same cycle out_val=0, busy=0, in_rdy=1; next word starts at idx 0 with its own data.
REQ-036 Downstream check: outputs connected to an 8x4 deserialized register (out_idx as subword index, write on fire) -> register equals each accepted word after its last beat.

Source files
------------

// File: rtl/param_nibble_serializer.sv
// param_nibble_serializer
//
// Takes one parallel word and emits it as NUM_SUBWORDS subwords, LSB-first,
// over a valid/ready stream. A new word can be loaded on the same edge that
// the last subword of the previous word is taken, so a steady stream of words
// runs with no idle cycle between them.
//
// Ports
//   clk       single clock, all state updates on its rising edge
//   reset     asynchronous, active-high; aborts any word in flight
//   in_val    parallel word valid
//   in_rdy    serializer can accept a parallel word (combinational on out_rdy)
//   in_data   parallel word, WORD_W bits
//   out_val   serial subword valid
//   out_rdy   downstream accepts the current subword
//   out_data  current subword, SUBWORD_W bits
//   out_idx   index of out_data within its word (0 = least significant)
//   out_last  current subword is the final one of its word
//   busy      a word is held and not yet fully transferred
module param_nibble_serializer #(
  parameter int NUM_SUBWORDS = 8,
  parameter int SUBWORD_W    = 4,
  localparam int WORD_W      = NUM_SUBWORDS * SUBWORD_W,
  localparam int IDX_W       = $clog2(NUM_SUBWORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [WORD_W-1:0]    in_data,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [SUBWORD_W-1:0] out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SUBWORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [WORD_W-1:0] shift_r;

  logic send_s;
  logic last_s;
  logic last_fire_s;

  assign send_s      = (state_r == SEND);
  assign last_s      = send_s && (idx_r == LAST_IDX);
  assign last_fire_s = last_s && out_rdy;

  // Word/beat sequencing: load, shift-out, back-to-back reload and drain to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      shift_r <= {WORD_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_val) begin
            shift_r <= in_data;
            idx_r   <= {IDX_W{1'b0}};
            state_r <= SEND;
          end
        end
        SEND: begin
          if (out_rdy) begin
            if (idx_r == LAST_IDX) begin
              if (in_val) begin
                // Next word follows immediately; no bubble.
                shift_r <= in_data;
                idx_r   <= {IDX_W{1'b0}};
                state_r <= SEND;
              end else begin
                // Shifting out the final subword leaves the register all zero.
                shift_r <= shift_r >> SUBWORD_W;
                idx_r   <= {IDX_W{1'b0}};
                state_r <= IDLE;
              end
            end else begin
              shift_r <= shift_r >> SUBWORD_W;
              idx_r   <= idx_r + IDX_ONE;
              state_r <= SEND;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {IDX_W{1'b0}};
          shift_r <= {WORD_W{1'b0}};
        end
      endcase
    end
  end

  // Outputs are straight decodes of the registered state; only in_rdy looks at
  // out_rdy so that a waiting word can be taken on the last-beat edge.
  assign in_rdy   = !send_s || last_fire_s;
  assign out_val  = send_s;
  assign busy     = send_s;
  assign out_data = shift_r[SUBWORD_W-1:0];
  assign out_idx  = idx_r;
  assign out_last = last_s;

endmodule
